mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus load-data formatter for the 5-stage pipelined MIPS CPU.
- Captures each MEM-stage result and extracts/extends byte, halfword or word load data (big-endian).
- Drives the register file write port (write_register/write_data/write_enable) one cycle later.
- Provides the EX forwarding source, a retire counter and a sticky misaligned-access fault record.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  replace the incoming MEM instruction with a bubble.
- in_valid  input  1  MEM stage holds a real instruction.
- in_reg_write  input  1  instruction writes a GPR.
- in_mem_to_reg  input  1  result comes from memory (load), else from in_alu_result.
- in_load_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- in_load_unsigned  input  1  zero-extend sub-word loads (LBU/LHU).
- in_alu_result  input  32  ALU result; for loads, the byte address.
- in_mem_rdata  input  32  aligned word read from data memory.
- in_write_register  input  5  destination GPR.
- write_register  output  5  to register file.
- write_data  output  32  to register file and forwarding mux.
- write_enable  output  1  to register file.
- wb_valid  output  1  WB stage holds a real instruction this cycle.
- retired_count  output  CNT_W  number of instructions retired.
- misaligned_fault  output  1  sticky: a misaligned load reached WB.
- fault_addr  output  32  address of the first misaligned load.

Behaviour:
- All state updates on posedge clk. Priority: reset > flush > normal capture. No stall input: upstream delivers a bubble (in_valid=0) when stalled.
- Reset: wb_valid=0, write_enable=0, write_register=0, write_data=0, retired_count=0, misaligned_fault=0, fault_addr=0.
- Flush (no reset): stage loads a bubble: wb_valid=0, write_enable=0, write_register=0, write_data=0. Counter and fault record unchanged.
- Normal capture: the stage registers load from the inputs each cycle. Latency is exactly 1 cycle from input to outputs.
- Load formatting (combinational before the register), with a = in_alu_result[1:0]:
  - byte: lane a=0 -> rdata[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]. Sign-extend unless in_load_unsigned.
  - halfword: a[1]=0 -> [31:16], a[1]=1 -> [15:0]. Extend as for byte.
  - word: rdata unchanged.
- Non-load: write_data <= in_alu_result, regardless of the load fields.
- Misaligned: in_valid & in_mem_to_reg & ((halfword & a[0]) | (word & a != 0)). Data is registered as formatted, but write_enable is suppressed.
- write_enable <= in_valid & in_reg_write & (in_write_register != 0) & !misaligned. Writes to $0 are never issued.
- wb_valid <= in_valid. A misaligned load still counts as retired.
- retired_count increments by 1 on each cycle whose registered wb_valid is 1. It wraps modulo 2^CNT_W, and the counter update uses the current wb_valid, not the incoming one.
- Fault record: on the first misaligned capture, misaligned_fault <= 1 and fault_addr <= in_alu_result. Later faults do not overwrite. Cleared only by reset.
- Reset asserted mid-stream discards the in-flight instruction; nothing is written that cycle.
- Flush and a misaligned load in the same cycle: flush wins, and no fault is recorded.

Decomposition:
- Shared CPU package: load-size encodings (LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10) and the GPR index width (5). The same encodings are used by the MEM and ID stages.
- One natural sub-module: load_formatter, purely combinational. Inputs: rdata, addr[1:0], size, unsigned. Outputs: data and misaligned.
- The pipeline register, counter and fault record stay in mem_wb_stage.

Test Plan:
- Reset, then in_valid=1, reg_write=1, mem_to_reg=0, alu=0x12345678, rd=5 -> next cycle: write_enable=1, write_register=5, write_data=0x12345678, wb_valid=1. The following cycle: retired_count=1.
- LB with rdata=0x80FF7F01, addr low bits 0..3 -> write_data 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001. With LBU, addr 0 -> 0x00000080.
- LH with rdata=0x8001_7FFE: addr 0 -> 0xFFFF8001; addr 2 -> 0x00007FFE. LHU addr 0 -> 0x00008001.
- LW at addr 0x1002 -> write_enable=0, wb_valid=1, misaligned_fault=1, fault_addr=0x00001002. A later LH at 0x2001 leaves fault_addr=0x00001002.
- Valid ALU op with rd=0 -> write_enable=0, retired_count still increments.
- Flush asserted with a valid input -> next cycle wb_valid=0, write_enable=0. Reset asserted while wb_valid=1 -> next cycle all outputs 0 and retired_count=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions: load-size encodings, GPR index width and the
// sub-word extension helpers used by the load path.
package mem_wb_stage_pkg;

   localparam int WORD_W = 32;
   localparam int GPR_W  = 5;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   function automatic logic [WORD_W-1:0] extend8(input logic [7:0] b, input logic is_unsigned);
      return {{(WORD_W-8){b[7] & ~is_unsigned}}, b};
   endfunction

   function automatic logic [WORD_W-1:0] extend16(input logic [15:0] h, input logic is_unsigned);
      return {{(WORD_W-16){h[15] & ~is_unsigned}}, h};
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Big-endian lane extraction and sign/zero extension of load data, plus the
// alignment check for the requested access size.
module mem_wb_stage_load_formatter
   import mem_wb_stage_pkg::*;
(
   input  logic [WORD_W-1:0] rdata,
   input  logic [1:0]        addr,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   output logic [WORD_W-1:0] data,
   output logic              misaligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      // Byte address 0 is the most significant lane of the word.
      case (addr)
         2'd0:    byte_lane = rdata[31:24];
         2'd1:    byte_lane = rdata[23:16];
         2'd2:    byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      data       = rdata;
      misaligned = 1'b0;
      case (size)
         LS_BYTE: data = extend8(byte_lane, load_unsigned);
         LS_HALF: begin
            data       = extend16(half_lane, load_unsigned);
            misaligned = addr[0];
         end
         // Reserved encoding behaves as a word access.
         default: misaligned = (addr != 2'b00);
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM result, drives the register-file
// write port one cycle later, counts retirements and records the first misaligned load.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic [1:0]        in_load_size,
   input  logic              in_load_unsigned,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_rdata,
   input  logic [GPR_W-1:0]  in_write_register,
   output logic [GPR_W-1:0]  write_register,
   output logic [DATA_W-1:0] write_data,
   output logic              write_enable,
   output logic              wb_valid,
   output logic [CNT_W-1:0]  retired_count,
   output logic              misaligned_fault,
   output logic [DATA_W-1:0] fault_addr
);

   logic [DATA_W-1:0] fmt_data;
   logic              fmt_misaligned;
   logic              misaligned_next;
   logic              write_enable_next;
   logic [DATA_W-1:0] write_data_next;

   logic [GPR_W-1:0]  write_register_reg;
   logic [DATA_W-1:0] write_data_reg;
   logic              write_enable_reg;
   logic              wb_valid_reg;
   logic [CNT_W-1:0]  retired_count_reg;
   logic              misaligned_fault_reg;
   logic [DATA_W-1:0] fault_addr_reg;

   mem_wb_stage_load_formatter u_load_formatter (
      .rdata         (in_mem_rdata),
      .addr          (in_alu_result[1:0]),
      .size          (in_load_size),
      .load_unsigned (in_load_unsigned),
      .data          (fmt_data),
      .misaligned    (fmt_misaligned)
   );

   // Only a real load can fault; ALU ops ignore the load fields entirely.
   assign misaligned_next   = in_valid & in_mem_to_reg & fmt_misaligned;
   assign write_enable_next = in_valid & in_reg_write & (in_write_register != '0) & ~misaligned_next;
   assign write_data_next   = in_mem_to_reg ? fmt_data : in_alu_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         write_register_reg   <= '0;
         write_data_reg       <= '0;
         write_enable_reg     <= 1'b0;
         wb_valid_reg         <= 1'b0;
         retired_count_reg    <= '0;
         misaligned_fault_reg <= 1'b0;
         fault_addr_reg       <= '0;
      end else begin
         // Retirement is counted for the instruction currently in WB.
         retired_count_reg <= retired_count_reg + {{(CNT_W-1){1'b0}}, wb_valid_reg};
         if (flush) begin
            write_register_reg <= '0;
            write_data_reg     <= '0;
            write_enable_reg   <= 1'b0;
            wb_valid_reg       <= 1'b0;
         end else begin
            write_register_reg <= in_write_register;
            write_data_reg     <= write_data_next;
            write_enable_reg   <= write_enable_next;
            wb_valid_reg       <= in_valid;
            if (misaligned_next && !misaligned_fault_reg) begin
               misaligned_fault_reg <= 1'b1;
               fault_addr_reg       <= in_alu_result;
            end
         end
      end
   end

   assign write_register   = write_register_reg;
   assign write_data       = write_data_reg;
   assign write_enable     = write_enable_reg;
   assign wb_valid         = wb_valid_reg;
   assign retired_count    = retired_count_reg;
   assign misaligned_fault = misaligned_fault_reg;
   assign fault_addr       = fault_addr_reg;

endmodule
